// File: rtl/iterative_right_shifter.sv
// Multi-cycle right shifter that moves one bit per clock, with logical or
// arithmetic fill, and a start/busy/done handshake.
module iterative_right_shifter #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             arith,
  input  logic [WIDTH-1:0] data_in,
  input  logic [WIDTH-1:0] shamt_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t             state;
  state_t             state_next;
  logic [WIDTH-1:0]   result_q;
  logic [SHAMT_W-1:0] count;
  logic               arith_q;
  logic               load;
  logic               fill;
  logic [SHAMT_W-1:0] shamt;
  logic               unused_shamt_hi;

  // MIPS semantics: only the low bits of the shift amount matter.
  assign shamt           = shamt_in[SHAMT_W-1:0];
  assign unused_shamt_hi = ^shamt_in[WIDTH-1:SHAMT_W];
  assign fill            = arith_q & result_q[WIDTH-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // A request is accepted from IDLE or DONE; a zero count skips SHIFT entirely.
  always_comb begin
    state_next = state;
    load       = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          load       = 1'b1;
          state_next = (shamt == '0) ? DONE : SHIFT;
        end
      end
      SHIFT: begin
        if (count == SHAMT_W'(1)) begin
          state_next = DONE;
        end
      end
      DONE: begin
        if (start) begin
          load       = 1'b1;
          state_next = (shamt == '0) ? DONE : SHIFT;
        end else begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_q <= '0;
      count    <= '0;
      arith_q  <= 1'b0;
    end else if (load) begin
      result_q <= data_in;
      count    <= shamt;
      arith_q  <= arith;
    end else if (state == SHIFT) begin
      result_q <= {fill, result_q[WIDTH-1:1]};
      count    <= count - SHAMT_W'(1);
    end
  end

  assign busy   = (state == SHIFT);
  assign done   = (state == DONE);
  assign result = result_q;

endmodule

// File: tb/tb_iterative_right_shifter.sv
// Directed bench for iterative_right_shifter: a cycle-level reference model
// checked every cycle, plus hand-computed expectations for each scenario.
module tb_iterative_right_shifter;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        arith;
  logic [31:0] data_in;
  logic [31:0] shamt_in;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int errors;
  int checks;
  int done_count;
  bit check_en;

  // Reference model state
  logic        m_active;
  logic        m_done;
  logic [31:0] m_result;
  logic [31:0] m_data;
  logic        m_arith;
  int          m_n;
  int          m_elapsed;

  iterative_right_shifter #(.WIDTH(32), .SHAMT_W(5)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .arith    (arith),
    .data_in  (data_in),
    .shamt_in (shamt_in),
    .busy     (busy),
    .done     (done),
    .result   (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] ref_shift(input logic [31:0] d, input int n, input logic a);
    if (a) return 32'($signed(d) >>> n);
    return d >> n;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  // Model: after acceptance, result after k shift edges is data shifted by k.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_active  <= 1'b0;
      m_done    <= 1'b0;
      m_result  <= '0;
      m_data    <= '0;
      m_arith   <= 1'b0;
      m_n       <= 0;
      m_elapsed <= 0;
    end else if (m_active) begin
      m_elapsed <= m_elapsed + 1;
      m_result  <= ref_shift(m_data, m_elapsed + 1, m_arith);
      m_done    <= (m_elapsed + 1 == m_n);
      m_active  <= (m_elapsed + 1 != m_n);
    end else if (start) begin
      m_data    <= data_in;
      m_arith   <= arith;
      m_n       <= int'(shamt_in % 32);
      m_elapsed <= 0;
      m_result  <= data_in;
      m_done    <= (shamt_in % 32 == 0);
      m_active  <= (shamt_in % 32 != 0);
    end else begin
      m_done <= 1'b0;
    end
  end

  always @(negedge clk) begin
    if (check_en) begin
      checkOutput("model_busy", {31'b0, busy}, {31'b0, m_active});
      checkOutput("model_done", {31'b0, done}, {31'b0, m_done});
      checkOutput("model_result", result, m_result);
      if (done) done_count++;
    end
  end

  task automatic applyStimulus(input logic [31:0] d, input logic [31:0] s, input logic a);
    @(negedge clk);
    data_in  = d;
    shamt_in = s;
    arith    = a;
    start    = 1'b1;
    @(negedge clk);
    start    = 1'b0;
  endtask

  task automatic waitDone(output int busy_cycles);
    busy_cycles = 0;
    for (int i = 0; i < 64; i++) begin
      if (done) break;
      if (busy) busy_cycles++;
      @(negedge clk);
    end
    checkOutput("done_seen", {31'b0, done}, 32'd1);
  endtask

  int bc;
  int dc_before;

  initial begin
    errors   = 0;
    checks   = 0;
    done_count = 0;
    check_en = 1'b0;
    rst_n    = 1'b0;
    start    = 1'b0;
    arith    = 1'b0;
    data_in  = '0;
    shamt_in = '0;
    repeat (2) @(negedge clk);
    checkOutput("reset_busy", {31'b0, busy}, 32'd0);
    checkOutput("reset_done", {31'b0, done}, 32'd0);
    checkOutput("reset_result", result, 32'd0);
    rst_n    = 1'b1;
    check_en = 1'b1;

    // 3 >> 1, result must stay put afterwards
    applyStimulus(32'h3, 32'd1, 1'b0);
    waitDone(bc);
    checkOutput("t1_busy_cycles", bc, 32'd1);
    checkOutput("t1_result", result, 32'h1);
    repeat (3) @(negedge clk);
    checkOutput("t1_hold", result, 32'h1);
    checkOutput("t1_no_done", {31'b0, done}, 32'd0);

    // maximum shift, arithmetic then logical
    applyStimulus(32'h80000000, 32'd31, 1'b1);
    waitDone(bc);
    checkOutput("t2a_busy_cycles", bc, 32'd31);
    checkOutput("t2a_result", result, 32'hFFFFFFFF);
    @(negedge clk);
    applyStimulus(32'h80000000, 32'd31, 1'b0);
    waitDone(bc);
    checkOutput("t2b_busy_cycles", bc, 32'd31);
    checkOutput("t2b_result", result, 32'h00000001);

    // shamt of 32 wraps to a zero count
    @(negedge clk);
    applyStimulus(32'hA5A5A5A5, 32'h00000020, 1'b0);
    waitDone(bc);
    checkOutput("t3_busy_cycles", bc, 32'd0);
    checkOutput("t3_result", result, 32'hA5A5A5A5);

    // a start during busy is ignored
    @(negedge clk);
    dc_before = done_count;
    applyStimulus(32'hF0, 32'd4, 1'b0);
    data_in  = 32'hFFFF;
    shamt_in = 32'd8;
    start    = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    waitDone(bc);
    checkOutput("t4_result", result, 32'h0F);
    repeat (12) @(negedge clk);
    checkOutput("t4_done_once", done_count - dc_before, 32'd1);
    checkOutput("t4_result_hold", result, 32'h0F);

    // asynchronous reset mid-shift
    applyStimulus(32'h00010000, 32'd16, 1'b0);
    repeat (4) @(negedge clk);
    checkOutput("t5_busy_before", {31'b0, busy}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("t5_busy_async", {31'b0, busy}, 32'd0);
    checkOutput("t5_done_async", {31'b0, done}, 32'd0);
    checkOutput("t5_result_async", result, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    dc_before = done_count;
    repeat (20) @(negedge clk);
    checkOutput("t5_no_done", done_count - dc_before, 32'd0);
    applyStimulus(32'h00010000, 32'd16, 1'b0);
    waitDone(bc);
    checkOutput("t5_busy_cycles", bc, 32'd16);
    checkOutput("t5_result", result, 32'h1);

    // back-to-back: start held high across DONE
    @(negedge clk);
    data_in  = 32'h3;
    shamt_in = 32'd2;
    arith    = 1'b0;
    start    = 1'b1;
    @(negedge clk);
    waitDone(bc);
    checkOutput("t6a_busy_cycles", bc, 32'd2);
    checkOutput("t6a_result", result, 32'h0);
    shamt_in = 32'd3;
    @(negedge clk);
    start = 1'b0;
    checkOutput("t6_no_idle", {31'b0, busy}, 32'd1);
    waitDone(bc);
    checkOutput("t6b_busy_cycles", bc, 32'd3);
    checkOutput("t6b_result", result, 32'h0);
    @(negedge clk);
    checkOutput("t6_idle_after", {31'b0, done}, 32'd0);

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/iterative_right_shifter.md
Name: iterative_right_shifter

Overview:
- Multi-cycle 32-bit right shifter: logical (SRL/SRLV) or arithmetic (SRA/SRAV), one bit position per clock.
- Complements the combinational left shifter in the ALU datapath.
- Used by the multi-cycle execution path, where a full barrel shifter is too costly.
- Start/busy/done handshake; result held stable until the next accepted start.

Parameters:
- WIDTH, 32, data width in bits.
- SHAMT_W, 5, number of low bits of shamt_in used as the shift count (log2 WIDTH).

Ports:
- clk  input  1  system clock, rising-edge active.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request pulse; sampled on rising clk edges.
- arith  input  1  1 = arithmetic shift (sign-fill), 0 = logical shift (zero-fill); sampled with start.
- data_in  input  WIDTH  operand to shift; sampled with start.
- shamt_in  input  WIDTH  shift amount; only bits [SHAMT_W-1:0] used, upper bits ignored (MIPS semantics).
- busy  output  1  high while a shift is in progress (SHIFT state).
- done  output  1  single-cycle pulse; result valid.
- result  output  WIDTH  shifted value; holds the last completed result.

Behaviour:
- Reset (asynchronous, rst_n low): state=IDLE, result=0, busy=0, done=0, internal count=0, latched arith=0. Takes effect immediately, including mid-operation. An in-flight shift is discarded and no done is issued.
- States: IDLE, SHIFT, DONE.
- IDLE: start=1 at an edge loads result<=data_in, count<=shamt_in[SHAMT_W-1:0], sign-fill mode<=arith.
  - count==0: next state DONE.
  - Otherwise: next state SHIFT.
- SHIFT: each edge updates result<={fill, result[WIDTH-1:1]} and count<=count-1.
  - fill = result[WIDTH-1] if arith mode, else 0.
  - When count==1 at the edge, next state DONE; otherwise stay in SHIFT.
  - busy=1 in this state only.
- DONE: done=1 for exactly this one cycle.
  - start=1 at the exiting edge is accepted as a new request, with the same load behaviour as IDLE (back-to-back operation).
  - Otherwise next state IDLE.
- start in SHIFT is ignored; no queuing. data_in, shamt_in and arith changing during SHIFT have no effect.
- Latency: start accepted at edge k with shift count N gives done high during the cycle after edge k+N.
  - N=0: done in the cycle immediately after the start edge.
  - N=31: 31 busy cycles, then done.
- result changes only on a load edge or a SHIFT edge. It is stable during DONE and IDLE until the next accepted start.
- Arithmetic result equals signed data_in >>> N. Logical result equals data_in >> N. Both are exact for N in 0..31.
- All outputs are registered or decoded directly from state; no combinational path from inputs to outputs.

Test Plan:
- data_in=32'h3, shamt_in=1, arith=0, start pulse -> busy for 1 cycle, then done pulse with result=32'h1; result still 32'h1 three cycles later.
- data_in=32'h80000000, shamt_in=31, arith=1 -> busy for 31 cycles, done with result=32'hFFFFFFFF. Same operands with arith=0 -> result=32'h00000001.
- data_in=32'hA5A5A5A5, shamt_in=32'h00000020 (count 0) -> no busy, done in the next cycle with result=32'hA5A5A5A5.
- data_in=32'hF0, shamt_in=4, arith=0; second start with data_in=32'hFFFF, shamt_in=8 asserted during busy -> second request ignored; done once with result=32'h0F, and no further done.
- Start data_in=32'h00010000, shamt_in=16; rst_n low for 1 cycle after 5 busy cycles -> busy, done and result drop to 0 asynchronously; no done after release. A fresh start then completes normally.
- Back-to-back: start held high through DONE, first op 32'h3>>2 and second op 32'h3>>3 (arith=0) -> done pulses with result=32'h0 then result=32'h0, separated by exactly 3 busy cycles; no IDLE cycle between them.
